instruktion_lader: RTL

//  Boot loader for the instruction RAM. Consumes a byte stream and assembles it into 32-bit words.

---
 rtl/instruktion_lader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/instruktion_lader.sv
// Boot loader: byte stream -> 32-bit words -> instruction RAM.
// Holds the CPU in reset until the image is written.
module instruktion_lader #(
  parameter int WORDS        = 256,
  parameter int ADRESSBREITE = 8,
  parameter int TIMEOUT      = 1024,
  parameter int NACHLAUF     = 10
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [7:0]              ByteRein,
  input  logic                    ByteGueltig,
  output logic                    ByteBereit,
  output logic [31:0]             InstruktionDaten,
  output logic [ADRESSBREITE-1:0] InstruktionAdresse,
  output logic                    SchreibeInstruktion,
  input  logic                    InstruktionGeschrieben,
  output logic                    Initialisierung,
  output logic                    CPUReset,
  output logic                    Fertig,
  output logic                    Fehler
);

  localparam int CW = $clog2(WORDS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int NW = $clog2(NACHLAUF + 1);

  typedef enum logic [2:0] {
    S_LAENGE,
    S_DATEN,
    S_SCHREIBEN,
    S_PAUSE,
    S_NACHLAUF,
    S_FERTIG,
    S_FEHLER
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              bc_q, bc_d;
  logic [31:0]             n_q, n_d;
  logic [31:0]             data_q, data_d;
  logic [ADRESSBREITE-1:0] adr_q, adr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           cnt_nx;
  logic [TW-1:0]           to_q, to_d;
  logic [NW-1:0]           nl_q, nl_d;
  logic                    we_q, we_d;
  logic                    init_q, init_d;
  logic                    cpu_q, cpu_d;
  logic                    fertig_q, fertig_d;
  logic                    fehler_q, fehler_d;
  logic                    take;
  logic [31:0]             n_word;
  logic [31:0]             d_word;

  assign ByteBereit = ((state_q == S_LAENGE) ||
                       (state_q == S_DATEN)) && !Reset;
  assign take   = ByteGueltig && ByteBereit;
  assign n_word = {ByteRein, n_q[31:8]};
  assign d_word = {ByteRein, data_q[31:8]};
  assign cnt_nx = cnt_q + CW'(1);

  assign InstruktionDaten    = data_q;
  assign InstruktionAdresse  = adr_q;
  assign SchreibeInstruktion = we_q;
  assign Initialisierung     = init_q;
  assign CPUReset            = cpu_q;
  assign Fertig              = fertig_q;
  assign Fehler              = fehler_q;

  // Next state and datapath; the last word's PAUSE cycle
  // counts as the first cycle of the CPU reset tail.
  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    n_d     = n_q;
    data_d  = data_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    nl_d    = nl_q;
    unique case (state_q)
      S_LAENGE: begin
        if (take) begin
          n_d  = n_word;
          bc_d = bc_q + 2'd1;
          if (bc_q == 2'd3) begin
            if (n_word == 32'd0) begin
              state_d = S_NACHLAUF;
              nl_d    = NW'(NACHLAUF - 1);
            end else if (n_word > 32'(WORDS)) begin
              state_d = S_FEHLER;
            end else begin
              state_d = S_DATEN;
              adr_d   = '0;
              cnt_d   = '0;
            end
          end
        end
      end
      S_DATEN: begin
        if (take) begin
          data_d = d_word;
          bc_d   = bc_q + 2'd1;
          if (bc_q == 2'd3) begin
            state_d = S_SCHREIBEN;
            to_d    = '0;
          end
        end
      end
      S_SCHREIBEN: begin
        if (InstruktionGeschrieben) begin
          state_d = S_PAUSE;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          state_d = S_FEHLER;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_PAUSE: begin
        cnt_d = cnt_nx;
        if (32'(cnt_nx) == n_q) begin
          state_d = S_NACHLAUF;
          nl_d    = NW'(NACHLAUF - 2);
        end else begin
          state_d = S_DATEN;
          adr_d   = adr_q + ADRESSBREITE'(1);
        end
      end
      S_NACHLAUF: begin
        if (nl_q == '0) begin
          state_d = S_FERTIG;
        end else begin
          nl_d = nl_q - NW'(1);
        end
      end
      S_FERTIG: state_d = S_FERTIG;
      S_FEHLER: state_d = S_FEHLER;
      default:  state_d = S_LAENGE;
    endcase
    we_d     = (state_d == S_SCHREIBEN);
    init_d   = (state_d != S_NACHLAUF) &&
               (state_d != S_FERTIG);
    cpu_d    = (state_d != S_FERTIG);
    fertig_d = (state_d == S_FERTIG);
    fehler_d = (state_d == S_FEHLER);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_LAENGE;
      bc_q     <= '0;
      n_q      <= '0;
      data_q   <= '0;
      adr_q    <= '0;
      cnt_q    <= '0;
      to_q     <= '0;
      nl_q     <= '0;
      we_q     <= 1'b0;
      init_q   <= 1'b1;
      cpu_q    <= 1'b1;
      fertig_q <= 1'b0;
      fehler_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bc_q     <= bc_d;
      n_q      <= n_d;
      data_q   <= data_d;
      adr_q    <= adr_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      nl_q     <= nl_d;
      we_q     <= we_d;
      init_q   <= init_d;
      cpu_q    <= cpu_d;
      fertig_q <= fertig_d;
      fehler_q <= fehler_d;
    end
  end

endmodule
